// File: rtl/limp_cycle_controller.sv
// Tank cleaning cycle sequencer: drain, timed rinse passes, refill and an optional fertiliser dose.
// Valve and status outputs are a pure decode of the state register.
module limp_cycle_controller #(
    parameter int CNT_W         = 16,
    parameter int DRAIN_TIMEOUT = 1000,
    parameter int RINSE_TIME    = 200,
    parameter int RINSE_CYCLES  = 3,
    parameter int FILL_TIMEOUT  = 1000,
    parameter int DOSE_TIME     = 50
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_clear,
    input  logic       i_adb_req,
    input  logic       i_low,
    input  logic       i_high,
    output logic       o_ve,
    output logic       o_vs,
    output logic       o_vd,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_fault,
    output logic [1:0] o_fault_code,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAIN = 3'd1,
        S_RINSE = 3'd2,
        S_FILL  = 3'd3,
        S_DOSE  = 3'd4,
        S_DONE  = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] L_DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] L_RINSE_LAST = CNT_W'(RINSE_TIME - 1);
    localparam logic [CNT_W-1:0] L_FILL_LAST  = CNT_W'(FILL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] L_DOSE_LAST  = CNT_W'(DOSE_TIME - 1);
    localparam logic [CNT_W-1:0] L_TIMER_MAX  = '1;
    localparam logic [3:0]       L_PASS_LAST  = 4'(RINSE_CYCLES - 1);

    localparam logic [1:0] L_CODE_NONE     = 2'b00;
    localparam logic [1:0] L_CODE_DRAIN    = 2'b01;
    localparam logic [1:0] L_CODE_FILL     = 2'b10;
    localparam logic [1:0] L_CODE_CONFLICT = 2'b11;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_next;
    logic [3:0]       r_rinse_cnt;
    logic [3:0]       w_rinse_cnt_next;
    logic             r_dose_pend;
    logic             w_dose_pend_next;
    logic [1:0]       r_fault_code;
    logic [1:0]       w_fault_code_next;
    logic             w_timer_restart;
    logic             w_conflict;
    logic             w_active;

    assign w_conflict = i_low & i_high;
    assign w_active   = (r_state == S_DRAIN) || (r_state == S_RINSE) ||
                        (r_state == S_FILL)  || (r_state == S_DOSE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_rinse_cnt  <= '0;
            r_dose_pend  <= 1'b0;
            r_fault_code <= L_CODE_NONE;
        end else begin
            r_state      <= w_state_next;
            r_timer      <= w_timer_next;
            r_rinse_cnt  <= w_rinse_cnt_next;
            r_dose_pend  <= w_dose_pend_next;
            r_fault_code <= w_fault_code_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_rinse_cnt_next  = r_rinse_cnt;
        w_fault_code_next = r_fault_code;
        w_timer_restart   = 1'b0;

        // Conflict and abort pre-empt every active phase's own transitions.
        if (w_active && w_conflict) begin
            w_state_next      = S_FAULT;
            w_fault_code_next = L_CODE_CONFLICT;
        end else if (w_active && i_abort) begin
            w_state_next     = S_IDLE;
            w_rinse_cnt_next = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_state_next = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (i_low) begin
                        w_state_next     = S_RINSE;
                        w_rinse_cnt_next = '0;
                    end else if (r_timer == L_DRAIN_LAST) begin
                        w_state_next      = S_FAULT;
                        w_fault_code_next = L_CODE_DRAIN;
                    end
                end
                S_RINSE: begin
                    if (r_timer == L_RINSE_LAST) begin
                        if (r_rinse_cnt == L_PASS_LAST) begin
                            w_state_next = S_FILL;
                        end else begin
                            w_rinse_cnt_next = r_rinse_cnt + 4'd1;
                            w_timer_restart  = 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    // The full sensor is checked before the timeout so a coincident level wins.
                    if (i_high) begin
                        w_state_next = r_dose_pend ? S_DOSE : S_DONE;
                    end else if (r_timer == L_FILL_LAST) begin
                        w_state_next      = S_FAULT;
                        w_fault_code_next = L_CODE_FILL;
                    end
                end
                S_DOSE: begin
                    if (r_timer == L_DOSE_LAST) begin
                        w_state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    w_state_next = S_IDLE;
                end
                S_FAULT: begin
                    if (i_clear) begin
                        w_state_next      = S_IDLE;
                        w_fault_code_next = L_CODE_NONE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        if ((w_state_next != r_state) || w_timer_restart) begin
            w_timer_next = '0;
        end else if (r_timer != L_TIMER_MAX) begin
            w_timer_next = r_timer + CNT_W'(1);
        end else begin
            w_timer_next = r_timer;
        end
    end

    // A request on the same edge as the DOSE-entry clear keeps the flag set.
    always_comb begin
        w_dose_pend_next = r_dose_pend;
        if ((w_state_next == S_DOSE) && (r_state != S_DOSE)) begin
            w_dose_pend_next = 1'b0;
        end
        if (i_adb_req && (r_state != S_FAULT)) begin
            w_dose_pend_next = 1'b1;
        end
    end

    always_comb begin
        o_ve    = 1'b0;
        o_vs    = 1'b0;
        o_vd    = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        o_fault = 1'b0;
        case (r_state)
            S_DRAIN: begin
                o_vs   = 1'b1;
                o_busy = 1'b1;
            end
            S_RINSE: begin
                o_ve   = 1'b1;
                o_vs   = 1'b1;
                o_busy = 1'b1;
            end
            S_FILL: begin
                o_ve   = 1'b1;
                o_busy = 1'b1;
            end
            S_DOSE: begin
                o_vd   = 1'b1;
                o_busy = 1'b1;
            end
            S_DONE:  o_done  = 1'b1;
            S_FAULT: o_fault = 1'b1;
            default: ;
        endcase
    end

    assign o_fault_code = r_fault_code;
    assign o_state      = r_state;

endmodule

// File: tb/tb_limp_cycle_controller.sv
// Directed-vector bench for limp_cycle_controller with short phase parameters.
`timescale 1ns/1ps
module tb_limp_cycle_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0, clear = 1'b0, adb_req = 1'b0;
    logic       low = 1'b0, high = 1'b0;
    logic       ve, vs, vd, busy, done, fault;
    logic [1:0] fault_code;
    logic [2:0] state;
    logic [10:0] obs;

    int checks = 0;
    int errors = 0;

    // {state, ve, vs, vd, busy, done, fault, fault_code}
    localparam logic [10:0] E_IDLE   = 11'b000_0_0_0_0_0_0_00;
    localparam logic [10:0] E_DRAIN  = 11'b001_0_1_0_1_0_0_00;
    localparam logic [10:0] E_RINSE  = 11'b010_1_1_0_1_0_0_00;
    localparam logic [10:0] E_FILL   = 11'b011_1_0_0_1_0_0_00;
    localparam logic [10:0] E_DOSE   = 11'b100_0_0_1_1_0_0_00;
    localparam logic [10:0] E_DONE   = 11'b101_0_0_0_0_1_0_00;
    localparam logic [10:0] E_FLT_DR = 11'b110_0_0_0_0_0_1_01;
    localparam logic [10:0] E_FLT_FL = 11'b110_0_0_0_0_0_1_10;
    localparam logic [10:0] E_FLT_CF = 11'b110_0_0_0_0_0_1_11;

    limp_cycle_controller #(
        .CNT_W(16), .DRAIN_TIMEOUT(20), .RINSE_TIME(4), .RINSE_CYCLES(2),
        .FILL_TIMEOUT(20), .DOSE_TIME(3)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_clear(clear), .i_adb_req(adb_req), .i_low(low), .i_high(high),
        .o_ve(ve), .o_vs(vs), .o_vd(vd), .o_busy(busy), .o_done(done),
        .o_fault(fault), .o_fault_code(fault_code), .o_state(state)
    );

    always #5 clk = ~clk;
    assign obs = {state, ve, vs, vd, busy, done, fault, fault_code};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in its first FILL cycle.
    task automatic go_to_fill();
        start = 1'b1; tick(); start = 1'b0;
        low = 1'b1; tick(); low = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++;
        if (obs !== E_IDLE) begin errors++; $display("FAIL reset_state got %b exp %b", obs, E_IDLE); end
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== E_IDLE) begin errors++; $display("FAIL reset_release got %b exp %b", obs, E_IDLE); end
        $display("txn reset: obs=%b", obs);
    endtask

    task automatic test_full_cycle();
        adb_req = 1'b1; tick(); adb_req = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== E_DRAIN) begin errors++; $display("FAIL full_drain cyc%0d got %b exp %b", i, obs, E_DRAIN); end
            if (i == 4) low = 1'b1;
            tick();
        end
        low = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs !== E_RINSE) begin errors++; $display("FAIL full_rinse cyc%0d got %b exp %b", i, obs, E_RINSE); end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== E_FILL) begin errors++; $display("FAIL full_fill cyc%0d got %b exp %b", i, obs, E_FILL); end
            if (i == 2) high = 1'b1;
            tick();
        end
        high = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== E_DOSE) begin errors++; $display("FAIL full_dose cyc%0d got %b exp %b", i, obs, E_DOSE); end
            tick();
        end
        checks++;
        if (obs !== E_DONE) begin errors++; $display("FAIL full_done got %b exp %b", obs, E_DONE); end
        tick();
        checks++;
        if (obs !== E_IDLE) begin errors++; $display("FAIL full_idle got %b exp %b", obs, E_IDLE); end
        $display("txn full_cycle: end obs=%b", obs);
    endtask

    // A second cycle without adb_req must skip DOSE, proving dose_pend was cleared.
    task automatic test_back_to_back();
        go_to_fill();
        high = 1'b1; tick(); high = 1'b0;
        checks++;
        if (obs !== E_DONE) begin errors++; $display("FAIL b2b_no_dose got %b exp %b", obs, E_DONE); end
        tick();
        checks++;
        if (obs !== E_IDLE) begin errors++; $display("FAIL b2b_idle got %b exp %b", obs, E_IDLE); end
        $display("txn back_to_back: obs=%b", obs);
    endtask

    task automatic test_drain_timeout();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (obs !== E_DRAIN) begin errors++; $display("FAIL dto_drain cyc%0d got %b exp %b", i, obs, E_DRAIN); end
            tick();
        end
        checks++;
        if (obs !== E_FLT_DR) begin errors++; $display("FAIL dto_fault got %b exp %b", obs, E_FLT_DR); end
        start = 1'b1; tick(); start = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        checks++;
        if (obs !== E_FLT_DR) begin errors++; $display("FAIL dto_hold got %b exp %b", obs, E_FLT_DR); end
        clear = 1'b1; tick(); clear = 1'b0;
        checks++;
        if (obs !== E_IDLE) begin errors++; $display("FAIL dto_clear got %b exp %b", obs, E_IDLE); end
        $display("txn drain_timeout: obs=%b", obs);
    endtask

    task automatic test_fill_sensor_wins();
        go_to_fill();
        repeat (19) tick();
        checks++;
        if (obs !== E_FILL) begin errors++; $display("FAIL fsw_fill20 got %b exp %b", obs, E_FILL); end
        high = 1'b1; tick(); high = 1'b0;
        checks++;
        if (obs !== E_DONE) begin errors++; $display("FAIL fsw_done got %b exp %b", obs, E_DONE); end
        tick();
        $display("txn fill_sensor_wins: obs=%b", obs);
    endtask

    task automatic test_fill_timeout();
        go_to_fill();
        repeat (19) tick();
        checks++;
        if (obs !== E_FILL) begin errors++; $display("FAIL fto_fill20 got %b exp %b", obs, E_FILL); end
        tick();
        checks++;
        if (obs !== E_FLT_FL) begin errors++; $display("FAIL fto_fault got %b exp %b", obs, E_FLT_FL); end
        clear = 1'b1; tick(); clear = 1'b0;
        checks++;
        if (obs !== E_IDLE) begin errors++; $display("FAIL fto_clear got %b exp %b", obs, E_IDLE); end
        $display("txn fill_timeout: obs=%b", obs);
    endtask

    task automatic test_conflict();
        start = 1'b1; tick(); start = 1'b0;
        low = 1'b1; tick(); low = 1'b0;
        tick();
        checks++;
        if (obs !== E_RINSE) begin errors++; $display("FAIL cfl_rinse got %b exp %b", obs, E_RINSE); end
        low = 1'b1; high = 1'b1; abort = 1'b1;
        tick();
        low = 1'b0; high = 1'b0; abort = 1'b0;
        checks++;
        if (obs !== E_FLT_CF) begin errors++; $display("FAIL cfl_fault got %b exp %b", obs, E_FLT_CF); end
        clear = 1'b1; tick(); clear = 1'b0;
        checks++;
        if (obs !== E_IDLE) begin errors++; $display("FAIL cfl_clear got %b exp %b", obs, E_IDLE); end
        $display("txn conflict: obs=%b", obs);
    endtask

    task automatic test_abort_dose();
        adb_req = 1'b1; tick(); adb_req = 1'b0;
        go_to_fill();
        high = 1'b1; tick(); high = 1'b0;
        checks++;
        if (obs !== E_DOSE) begin errors++; $display("FAIL abd_dose got %b exp %b", obs, E_DOSE); end
        abort = 1'b1; tick(); abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== E_IDLE) begin errors++; $display("FAIL abd_idle cyc%0d got %b exp %b", i, obs, E_IDLE); end
            tick();
        end
        $display("txn abort_dose: obs=%b", obs);
    endtask

    task automatic test_async_reset();
        go_to_fill();
        tick();
        checks++;
        if (obs !== E_FILL) begin errors++; $display("FAIL ars_fill got %b exp %b", obs, E_FILL); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== E_IDLE) begin errors++; $display("FAIL ars_async got %b exp %b", obs, E_IDLE); end
        tick();
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if (obs !== E_IDLE) begin errors++; $display("FAIL ars_release got %b exp %b", obs, E_IDLE); end
        $display("txn async_reset: obs=%b", obs);
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_back_to_back();
        test_drain_timeout();
        test_fill_sensor_wins();
        test_fill_timeout();
        test_conflict();
        test_abort_dose();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
